tb_exit_monitor: RTL and testbench

- Memory-mapped end-of-computation monitor for multi-hart simulation and FPGA runs; replaces the single-GPIO end-of-test flag plus SPI return-code readback.
- Each hart writes its own exit code. The block merges all codes into one exit status and raises eoc_o when every enabled hart is done or the watchdog expires.
- Sits on the peripheral data bus (req/gnt/rvalid protocol). eoc_o and exit_status_o drive the testbench and board pins.

---
 rtl/tb_exit_pkg.sv | 18 +
 rtl/tb_exit_wdog.sv | 40 ++++
 rtl/tb_exit_monitor.sv | 167 ++++++++++++++++
 tb/tb_tb_exit_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tb_exit_pkg.sv
// Shared types and register map for the exit monitor.
// Offsets are byte addresses on the peripheral bus.
package tb_exit_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDone    = 2'd1,
    StTimeout = 2'd2
  } exit_state_e;

  localparam int unsigned CtrlOffset      = 32'h000;
  localparam int unsigned StatusOffset    = 32'h004;
  localparam int unsigned WdogLimitOffset = 32'h008;
  localparam int unsigned WdogCountOffset = 32'h00C;
  localparam int unsigned DoneOffset      = 32'h010;
  localparam int unsigned ExitBase        = 32'h100;

endpackage

// File: rtl/tb_exit_wdog.sv
// Saturating watchdog counter: counts while enabled with a nonzero limit and
// flags expiry in the cycle the count reaches limit - 1.
module tb_exit_wdog #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             armed;

  assign armed = en_i && (limit_i != '0);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (armed && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = armed && (count_q == limit_i - 1'b1);

endmodule

// File: rtl/tb_exit_monitor.sv
// Memory-mapped end-of-computation monitor: collects per-hart exit codes,
// merges them into one status and raises a sticky eoc_o on completion or timeout.
module tb_exit_monitor import tb_exit_pkg::*; #(
  parameter int unsigned        N_HARTS   = 3,
  parameter logic [N_HARTS-1:0] HART_MASK = {N_HARTS{1'b1}},
  parameter int unsigned        CODE_W    = 8,
  parameter int unsigned        CNT_W     = 32,
  parameter int unsigned        ADDR_W    = 12,
  parameter logic [CNT_W-1:0]   WDOG_RST  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [31:0]        wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               eoc_o,
  output logic [CODE_W-1:0]  exit_status_o,
  output logic               timeout_o,
  output logic [N_HARTS-1:0] hart_done_o
);

  exit_state_e                     state_q, state_d;
  logic [N_HARTS-1:0]              done_q, done_d;
  logic [N_HARTS-1:0][CODE_W-1:0]  code_q, code_d;
  logic                            err_q, err_d;
  logic [CNT_W-1:0]                limit_q, limit_d;
  logic [CODE_W-1:0]               status_q, status_d;
  logic                            rvalid_q;
  logic [31:0]                     rdata_q, rdata_d;

  logic                            wr_en, rd_en, ctrl_clr, limit_wr, all_done;
  logic [N_HARTS-1:0]              exit_hit;
  logic [CODE_W-1:0]               agg_code;
  logic [CNT_W-1:0]                wdog_count;
  logic                            wdog_expire, run_en;
  logic                            unused_be;

  assign unused_be = ^be_i[3:1];

  assign wr_en    = req_i & we_i & be_i[0];
  assign rd_en    = req_i & ~we_i;
  assign ctrl_clr = wr_en && (addr_i == ADDR_W'(CtrlOffset)) && wdata_i[0];
  assign limit_wr = wr_en && (addr_i == ADDR_W'(WdogLimitOffset));
  assign all_done = (done_q & HART_MASK) == HART_MASK;
  assign run_en   = (state_q == StRun);

  always_comb begin
    exit_hit = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      exit_hit[h] = (addr_i == ADDR_W'(ExitBase + 4 * h));
    end
  end

  // Walk from the top so the lowest-index nonzero masked code wins.
  always_comb begin
    agg_code = '0;
    for (int h = N_HARTS - 1; h >= 0; h--) begin
      if (HART_MASK[h] && (code_q[h] != '0)) begin
        agg_code = code_q[h];
      end
    end
  end

  tb_exit_wdog #(
    .CNT_W(CNT_W)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (run_en),
    .clr_i   (ctrl_clr | limit_wr),
    .limit_i (limit_q),
    .count_o (wdog_count),
    .expire_o(wdog_expire)
  );

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    code_d   = code_q;
    err_d    = err_q;
    limit_d  = limit_q;
    status_d = status_q;

    if (limit_wr) begin
      limit_d = CNT_W'(wdata_i);
    end

    for (int h = 0; h < N_HARTS; h++) begin
      if (wr_en && exit_hit[h]) begin
        if (done_q[h]) begin
          err_d = 1'b1;
        end else begin
          code_d[h] = wdata_i[CODE_W-1:0];
          done_d[h] = 1'b1;
        end
      end
    end

    // Completion takes priority over a simultaneous watchdog expiry.
    if (state_q == StRun) begin
      if (all_done) begin
        state_d  = StDone;
        status_d = agg_code;
      end else if (wdog_expire) begin
        state_d  = StTimeout;
        status_d = '1;
      end
    end

    if (ctrl_clr) begin
      state_d  = StRun;
      done_d   = '0;
      code_d   = '0;
      err_d    = 1'b0;
      status_d = '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      if (addr_i == ADDR_W'(StatusOffset))    rdata_d = {29'b0, err_q, state_q};
      if (addr_i == ADDR_W'(WdogLimitOffset)) rdata_d = 32'(limit_q);
      if (addr_i == ADDR_W'(WdogCountOffset)) rdata_d = 32'(wdog_count);
      if (addr_i == ADDR_W'(DoneOffset))      rdata_d = 32'(done_q);
      for (int h = 0; h < N_HARTS; h++) begin
        if (exit_hit[h]) rdata_d = 32'(code_q[h]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      done_q   <= '0;
      code_q   <= '0;
      err_q    <= 1'b0;
      limit_q  <= WDOG_RST;
      status_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      code_q   <= code_d;
      err_q    <= err_d;
      limit_q  <= limit_d;
      status_q <= status_d;
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt_o         = req_i;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign eoc_o         = (state_q != StRun);
  assign timeout_o     = (state_q == StTimeout);
  assign exit_status_o = status_q;
  assign hart_done_o   = done_q;

endmodule

// File: tb/tb_tb_exit_monitor.sv
// Directed bench for tb_exit_monitor with three harts, 8-bit codes and the
// watchdog disabled at reset.
module tb_tb_exit_monitor;

  localparam logic [11:0] ACtrl   = 12'h000;
  localparam logic [11:0] AStatus = 12'h004;
  localparam logic [11:0] ALimit  = 12'h008;
  localparam logic [11:0] ACount  = 12'h00C;
  localparam logic [11:0] ADone   = 12'h010;
  localparam logic [11:0] AExit0  = 12'h100;
  localparam logic [11:0] AExit1  = 12'h104;
  localparam logic [11:0] AExit2  = 12'h108;

  logic        clk, rst_n, req_i, we_i;
  logic [3:0]  be_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, eoc_o, timeout_o;
  logic [31:0] rdata_o;
  logic [7:0]  exit_status_o;
  logic [2:0]  hart_done_o;

  int total = 0;
  int bad   = 0;

  tb_exit_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .eoc_o        (eoc_o),
    .exit_status_o(exit_status_o),
    .timeout_o    (timeout_o),
    .hart_done_o  (hart_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single access; returns 1ns after the edge that accepted it.
  task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = be;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    #12;
    total++; if (eoc_o !== 1'b0) begin bad++; $display("FAIL reset_eoc got=%h exp=0", eoc_o); end
    total++; if (exit_status_o !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", exit_status_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%h exp=0", timeout_o); end
    total++; if (hart_done_o !== 3'b000) begin bad++; $display("FAIL reset_done got=%h exp=0", hart_done_o); end
    total++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || gnt_o !== 1'b0) begin
      bad++; $display("FAIL reset_bus got rvalid=%h rdata=%h gnt=%h exp all 0", rvalid_o, rdata_o, gnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(AStatus, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_status_reg got=%h exp=0", r); end
    bus_read(ALimit, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_limit got=%h exp=0", r); end
  endtask

  task automatic test_all_zero();
    logic [31:0] r;
    bus_write(AExit0, 32'h0, 4'hF);
    bus_write(AExit1, 32'h0, 4'hF);
    bus_write(AExit2, 32'h0, 4'hF);
    total++; if (eoc_o !== 1'b0) begin bad++; $display("FAIL zero_eoc_early got=%h exp=0", eoc_o); end
    @(posedge clk); #1;
    total++; if (eoc_o !== 1'b1) begin bad++; $display("FAIL zero_eoc got=%h exp=1", eoc_o); end
    total++; if (exit_status_o !== 8'h00) begin bad++; $display("FAIL zero_status got=%h exp=00", exit_status_o); end
    bus_read(AStatus, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL zero_status_reg got=%h exp=1", r); end
    bus_write(ACtrl, 32'h1, 4'hF);
  endtask

  task automatic test_lowest_nonzero();
    logic [31:0] r;
    bus_write(ALimit, 32'd1000, 4'hF);
    bus_write(AExit2, 32'h05, 4'hF);
    bus_write(AExit1, 32'h03, 4'hF);
    bus_write(AExit0, 32'h00, 4'hF);
    @(posedge clk); #1;
    total++; if (exit_status_o !== 8'h03) begin bad++; $display("FAIL agg_status got=%h exp=03", exit_status_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL agg_timeout got=%h exp=0", timeout_o); end
    bus_read(ADone, r);
    total++; if (r !== 32'h7) begin bad++; $display("FAIL agg_done_reg got=%h exp=7", r); end
    bus_read(AExit2, r);
    total++; if (r !== 32'h5) begin bad++; $display("FAIL agg_exit2 got=%h exp=5", r); end
  endtask

  task automatic test_clear();
    logic [31:0] r;
    bus_write(ACtrl, 32'h1, 4'hF);
    total++; if (eoc_o !== 1'b0) begin bad++; $display("FAIL clr_eoc got=%h exp=0", eoc_o); end
    total++; if (hart_done_o !== 3'b000 || exit_status_o !== 8'h00) begin
      bad++; $display("FAIL clr_outs got done=%h status=%h exp 0/00", hart_done_o, exit_status_o);
    end
    bus_read(ADone, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL clr_done_reg got=%h exp=0", r); end
    bus_read(ALimit, r);
    total++; if (r !== 32'd1000) begin bad++; $display("FAIL clr_limit_kept got=%h exp=%h", r, 32'd1000); end
    bus_write(ALimit, 32'h0, 4'hF);
  endtask

  task automatic test_watchdog();
    logic [31:0] r;
    bus_write(ALimit, 32'd100, 4'hF);
    repeat (99) @(posedge clk);
    #1;
    total++; if (eoc_o !== 1'b0) begin bad++; $display("FAIL wdog_eoc_early got=%h exp=0", eoc_o); end
    @(posedge clk); #1;
    total++; if (eoc_o !== 1'b1 || timeout_o !== 1'b1) begin
      bad++; $display("FAIL wdog_expire got eoc=%h timeout=%h exp 1/1", eoc_o, timeout_o);
    end
    total++; if (exit_status_o !== 8'hFF) begin bad++; $display("FAIL wdog_status got=%h exp=ff", exit_status_o); end
    repeat (5) @(posedge clk);
    bus_read(ACount, r);
    total++; if (r !== 32'd100) begin bad++; $display("FAIL wdog_count got=%0d exp=100", r); end
    bus_read(AStatus, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL wdog_status_reg got=%h exp=2", r); end
    bus_write(ALimit, 32'h0, 4'hF);
    bus_write(ACtrl, 32'h1, 4'hF);
    bus_read(ACount, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL wdog_count_cleared got=%h exp=0", r); end
  endtask

  task automatic test_write_once();
    logic [31:0] r;
    bus_write(AExit1, 32'h11, 4'hF);
    bus_write(AExit1, 32'h22, 4'hF);
    bus_read(AExit1, r);
    total++; if (r !== 32'h11) begin bad++; $display("FAIL once_exit1 got=%h exp=11", r); end
    bus_read(AStatus, r);
    total++; if (r !== 32'h4) begin bad++; $display("FAIL once_err got=%h exp=4", r); end
    bus_write(AExit0, 32'h33, 4'hE);
    total++; if (hart_done_o !== 3'b010) begin bad++; $display("FAIL be0_drop got=%b exp=010", hart_done_o); end
    bus_write(ACtrl, 32'h1, 4'hF);
    bus_read(AStatus, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL once_err_clr got=%h exp=0", r); end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    bus_write(12'h10C, 32'h44, 4'hF);
    total++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
      bad++; $display("FAIL wr_rvalid got rvalid=%h rdata=%h exp 1/0", rvalid_o, rdata_o);
    end
    @(posedge clk); #1;
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rvalid_one_cycle got=%h exp=0", rvalid_o); end
    bus_write(12'h020, 32'h7, 4'hF);
    total++; if (hart_done_o !== 3'b000) begin bad++; $display("FAIL unmapped_done got=%b exp=000", hart_done_o); end
    bus_read(12'h10C, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", r); end
  endtask

  // Final exit lands on the edge that makes count reach limit-1, so the
  // registered done condition and the expiry are both true in the next cycle.
  task automatic test_done_vs_timeout();
    logic [31:0] r;
    bus_write(ALimit, 32'd10, 4'hF);
    bus_write(AExit0, 32'h00, 4'hF);
    bus_write(AExit1, 32'h07, 4'hF);
    repeat (6) @(posedge clk);
    bus_write(AExit2, 32'h09, 4'hF);
    total++; if (eoc_o !== 1'b0) begin bad++; $display("FAIL tie_eoc_early got=%h exp=0", eoc_o); end
    @(posedge clk); #1;
    total++; if (eoc_o !== 1'b1 || timeout_o !== 1'b0) begin
      bad++; $display("FAIL tie_state got eoc=%h timeout=%h exp 1/0", eoc_o, timeout_o);
    end
    total++; if (exit_status_o !== 8'h07) begin bad++; $display("FAIL tie_status got=%h exp=07", exit_status_o); end
    bus_read(AStatus, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL tie_status_reg got=%h exp=1", r); end
    bus_write(ALimit, 32'h0, 4'hF);
    bus_write(ACtrl, 32'h1, 4'hF);
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    bus_write(ALimit, 32'd50, 4'hF);
    bus_write(AExit0, 32'h05, 4'hF);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = AStatus;
    #2;
    rst_n = 1'b0; req_i = 1'b0;
    #1;
    total++; if (hart_done_o !== 3'b000 || rvalid_o !== 1'b0 || eoc_o !== 1'b0) begin
      bad++; $display("FAIL arst_outs got done=%b rvalid=%h eoc=%h exp all 0", hart_done_o, rvalid_o, eoc_o);
    end
    @(posedge clk); #1;
    total++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
      bad++; $display("FAIL arst_pending got rvalid=%h rdata=%h exp 0/0", rvalid_o, rdata_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(ALimit, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL arst_limit got=%h exp=0", r); end
    bus_read(AExit0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL arst_exit0 got=%h exp=0", r); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_lowest_nonzero();
    test_clear();
    test_watchdog();
    test_write_once();
    test_unmapped();
    test_done_vs_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
